// File: rtl/shift_sequencer.sv
// shift_sequencer
// ---------------------------------------------------------------------------
// Multi-cycle shift/rotate engine for the CPU datapath's 32-bit shifter path.
// An operation is captured on an accepted start, then shifted STEP positions
// per clock until the effective count is used up. done pulses for one cycle
// with the result, and out holds until the next accepted start.
//
// Handshake: start is sampled only on an edge where the FSM is IDLE; a start
// seen in SHIFT or DONE is dropped, never queued. busy (SHIFT or DONE) is
// decoded from state alone so the control unit can stall on it without an
// input-to-output path. done is high exactly one cycle (the DONE state), and
// out is valid whenever done is high and stays stable until the next accepted
// start.
//
// Optional feature: define SHIFT_SEQ_ABORT_EN to add the abort input. abort
// high on an edge in SHIFT or DONE returns the FSM to IDLE without a done
// pulse; out keeps its partial value and the remaining count is cleared.
// abort in IDLE does nothing, so start wins when both are high there.
//
// Parameters:
//   STEP   positions shifted per SHIFT cycle (power of two, 1..16)
//   CNT_W  width of the remaining-count register (must hold 0..32)
//
// Ports:
//   clock       system clock, rising edge
//   reset_n     asynchronous active-low reset
//   start       request pulse, sampled only in IDLE
//   abort       (SHIFT_SEQ_ABORT_EN only) cancel the operation in flight
//   op          000 SHL, 001 SHR, 010 SHRA, 011 ROL, 100 ROR, 101-111 illegal
//   data_in     operand to shift
//   num_shifts  unsigned shift amount
//   busy        high in SHIFT and DONE
//   done        one-cycle completion pulse
//   out         result register
//   illegal_op  sticky flag: last accepted start carried an illegal op
//   state_dbg   current FSM state (0 IDLE, 1 SHIFT, 2 DONE)
// ---------------------------------------------------------------------------
module shift_sequencer #(
  parameter int STEP  = 1,
  parameter int CNT_W = 6
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
`ifdef SHIFT_SEQ_ABORT_EN
  input  logic        abort,
`endif
  input  logic [2:0]  op,
  input  logic [31:0] data_in,
  input  logic [31:0] num_shifts,
  output logic        busy,
  output logic        done,
  output logic [31:0] out,
  output logic        illegal_op,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [2:0] OP_SHL  = 3'b000;
  localparam logic [2:0] OP_SHR  = 3'b001;
  localparam logic [2:0] OP_SHRA = 3'b010;
  localparam logic [2:0] OP_ROL  = 3'b011;
  localparam logic [2:0] OP_ROR  = 3'b100;

  localparam logic [CNT_W-1:0] STEP_C = CNT_W'(STEP);

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  count;
  logic [2:0]        op_q;
  logic [CNT_W-1:0]  eff_cnt;
  logic [CNT_W-1:0]  shift_k;
  logic [5:0]        sh;
  logic [31:0]       shifted;
  logic              abort_hit;

  // -------------------------------------------------------------------------
  // Effective count of the incoming request. Shifts saturate at 32 (anything
  // larger, including values with upper bits set, produces the same result);
  // rotates only care about the amount modulo 32; illegal ops do nothing.
  // -------------------------------------------------------------------------
  always_comb begin
    eff_cnt = '0;
    case (op)
      OP_SHL, OP_SHR, OP_SHRA: begin
        if (num_shifts >= 32'd32) begin
          eff_cnt = CNT_W'(6'd32);
        end else begin
          eff_cnt = CNT_W'(num_shifts[5:0]);
        end
      end
      OP_ROL, OP_ROR: eff_cnt = CNT_W'(num_shifts[4:0]);
      default:        eff_cnt = '0;
    endcase
  end

  // Positions consumed this SHIFT cycle: the last cycle may be a partial step.
  always_comb begin
    shift_k = count;
    if (count > STEP_C) begin
      shift_k = STEP_C;
    end
  end

  assign sh = 6'(shift_k);

  // One step of the registered operation applied to the current result.
  // sh is never zero in SHIFT, so the rotate complement (32 - sh) stays
  // within 1..31.
  always_comb begin
    shifted = out;
    case (op_q)
      OP_SHL:  shifted = out << sh;
      OP_SHR:  shifted = out >> sh;
      OP_SHRA: shifted = $signed(out) >>> sh;
      OP_ROL:  shifted = (out << sh) | (out >> (6'd32 - sh));
      OP_ROR:  shifted = (out >> sh) | (out << (6'd32 - sh));
      default: shifted = out;
    endcase
  end

`ifdef SHIFT_SEQ_ABORT_EN
  assign abort_hit = abort && (state != ST_IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = (eff_cnt == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (count <= STEP_C) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    if (abort_hit) begin
      state_nxt = ST_IDLE;
    end
  end

  // -------------------------------------------------------------------------
  // Datapath registers. An abort in SHIFT still lets that cycle's step land
  // in out (the partial result reflects every SHIFT cycle that ran) but
  // clears the remaining count.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out        <= '0;
      count      <= '0;
      op_q       <= '0;
      illegal_op <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            out        <= data_in;
            op_q       <= op;
            count      <= eff_cnt;
            illegal_op <= (op > OP_ROR);
          end
        end
        ST_SHIFT: begin
          out <= shifted;
          if (abort_hit) begin
            count <= '0;
          end else begin
            count <= count - shift_k;
          end
        end
        default: begin
          if (abort_hit) begin
            count <= '0;
          end
        end
      endcase
    end
  end

  // Status outputs depend on state only.
  assign busy      = (state == ST_SHIFT) || (state == ST_DONE);
  assign done      = (state == ST_DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer
// ---------------------------------------------------------------------------
// Bench for shift_sequencer. Two instances share the operand inputs: one with
// STEP=1 and one with STEP=4, each with its own start. Expected results come
// from a reference model built on 64-bit concatenation arithmetic; expected
// latency is ceil(count/STEP)+1 edges counting the edge that samples start.
// Define SHIFT_SEQ_ABORT_EN to also exercise the abort input.
// ---------------------------------------------------------------------------
module tb_shift_sequencer;

  logic        clock;
  logic        reset_n;
  logic        start1;
  logic        start4;
  logic        abort1;
  logic        abort4;
  logic [2:0]  op;
  logic [31:0] data_in;
  logic [31:0] num_shifts;

  logic        busy1, done1, ill1;
  logic [31:0] out1;
  logic [1:0]  st1;
  logic        busy4, done4, ill4;
  logic [31:0] out4;
  logic [1:0]  st4;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------------------------------------------------------- clock/reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------------------------------------------------------- DUTs
  shift_sequencer #(.STEP(1), .CNT_W(6)) dut1 (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start1),
`ifdef SHIFT_SEQ_ABORT_EN
    .abort      (abort1),
`endif
    .op         (op),
    .data_in    (data_in),
    .num_shifts (num_shifts),
    .busy       (busy1),
    .done       (done1),
    .out        (out1),
    .illegal_op (ill1),
    .state_dbg  (st1)
  );

  shift_sequencer #(.STEP(4), .CNT_W(6)) dut4 (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start4),
`ifdef SHIFT_SEQ_ABORT_EN
    .abort      (abort4),
`endif
    .op         (op),
    .data_in    (data_in),
    .num_shifts (num_shifts),
    .busy       (busy4),
    .done       (done4),
    .out        (out4),
    .illegal_op (ill4),
    .state_dbg  (st4)
  );

  // ---------------------------------------------------------------- reference model
  function automatic int unsigned eff_count(input logic [2:0] o, input logic [31:0] n);
    if (o <= 3'd2) return (n >= 32'd32) ? 32 : int'(n);
    if (o <= 3'd4) return int'(n % 32);
    return 0;
  endfunction

  function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] d,
                                             input logic [31:0] n);
    int unsigned c;
    logic [63:0] w;
    c = eff_count(o, n);
    case (o)
      3'd0: begin w = {32'b0, d} << c;          return w[31:0];  end
      3'd1: begin w = {d, 32'b0} >> c;          return w[63:32]; end
      3'd2: begin w = {{32{d[31]}}, d} >> c;    return w[31:0];  end
      3'd3: begin w = {d, d} << c;              return w[63:32]; end
      3'd4: begin w = {d, d} >> c;              return w[31:0];  end
      default: return d;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] o, input logic [31:0] n, input int step);
    int unsigned c;
    c = eff_count(o, n);
    return int'((c + step - 1) / step) + 1;
  endfunction

  // ---------------------------------------------------------------- scoreboard
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------- driver
  // Pulses start on the selected instances, scrambles the operand inputs after
  // the sampling edge, optionally re-pulses start1 at edge repulse_at, then
  // watches a fixed 45-edge window and checks result, latency, busy length,
  // done pulse count, illegal flag and result hold.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] d,
                        input logic [31:0] n, input bit use1, input bit use4,
                        input int repulse_at);
    int lat1, lat4, busy_cnt1, busy_cnt4, done_cnt1, done_cnt4;
    logic [31:0] res1, res4, exp_res;
    logic r_ill1, r_ill4;
    lat1 = 0; lat4 = 0; busy_cnt1 = 0; busy_cnt4 = 0; done_cnt1 = 0; done_cnt4 = 0;
    res1 = '0; res4 = '0; r_ill1 = 1'b0; r_ill4 = 1'b0;
    exp_res = ref_result(o, d, n);
    @(negedge clock);
    op = o; data_in = d; num_shifts = n;
    start1 = use1; start4 = use4;
    for (int e = 1; e <= 45; e++) begin
      @(posedge clock);
      @(negedge clock);
      start1 = 1'b0;
      start4 = 1'b0;
      if (e == 1) begin
        data_in    = $urandom;
        op         = 3'($urandom_range(0, 7));
        num_shifts = $urandom_range(0, 40);
      end
      if (e == repulse_at) begin
        data_in    = $urandom;
        op         = 3'($urandom_range(0, 4));
        num_shifts = $urandom_range(1, 8);
        start1     = 1'b1;
      end
      if (busy1) busy_cnt1++;
      if (busy4) busy_cnt4++;
      if (done1) begin
        done_cnt1++;
        if (lat1 == 0) begin lat1 = e; res1 = out1; r_ill1 = ill1; end
      end
      if (done4) begin
        done_cnt4++;
        if (lat4 == 0) begin lat4 = e; res4 = out4; r_ill4 = ill4; end
      end
    end
    if (use1) begin
      check({tag, "/s1 result"},  res1, exp_res);
      check({tag, "/s1 latency"}, 32'(lat1), 32'(ref_latency(o, n, 1)));
      check({tag, "/s1 busy_len"}, 32'(busy_cnt1), 32'(ref_latency(o, n, 1)));
      check({tag, "/s1 done_cnt"}, 32'(done_cnt1), 32'd1);
      check({tag, "/s1 illegal"}, 32'(r_ill1), 32'(o > 3'd4));
      check({tag, "/s1 hold"},    out1, exp_res);
      check({tag, "/s1 ill_hold"}, 32'(ill1), 32'(o > 3'd4));
    end
    if (use4) begin
      check({tag, "/s4 result"},  res4, exp_res);
      check({tag, "/s4 latency"}, 32'(lat4), 32'(ref_latency(o, n, 4)));
      check({tag, "/s4 busy_len"}, 32'(busy_cnt4), 32'(ref_latency(o, n, 4)));
      check({tag, "/s4 done_cnt"}, 32'(done_cnt4), 32'd1);
      check({tag, "/s4 illegal"}, 32'(r_ill4), 32'(o > 3'd4));
      check({tag, "/s4 hold"},    out4, exp_res);
    end
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int late_done;
    logic [31:0] d;
    logic [31:0] n;
    logic [2:0]  o;

    reset_n = 1'b0; start1 = 1'b0; start4 = 1'b0; abort1 = 1'b0; abort4 = 1'b0;
    op = '0; data_in = '0; num_shifts = '0;
    repeat (3) @(posedge clock);
    #1;
    check("reset busy1", 32'(busy1), 32'd0);
    check("reset done1", 32'(done1), 32'd0);
    check("reset out1",  out1, 32'd0);
    check("reset ill1",  32'(ill1), 32'd0);
    check("reset state1", 32'(st1), 32'd0);
    check("reset out4",  out4, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // Directed cases from the plan.
    run_op("shl2",      3'd0, 32'hFFFF_FFF0, 32'd2,  1, 1, 0);
    run_op("shra40",    3'd2, 32'h8000_0000, 32'd40, 1, 1, 0);
    run_op("shr40",     3'd1, 32'h8000_0000, 32'd40, 1, 1, 0);
    run_op("shl_big",   3'd0, 32'hDEAD_BEEF, 32'h1000_0003, 1, 1, 0);
    run_op("ror33",     3'd4, 32'h0000_0001, 32'd33, 1, 1, 0);
    run_op("rol36",     3'd3, 32'h0000_0001, 32'd36, 1, 1, 0);
    run_op("shl0",      3'd0, 32'h1234_5678, 32'd0,  1, 1, 0);
    run_op("illegal6",  3'd6, 32'h1234_5678, 32'd9,  1, 1, 0);
    run_op("after_ill", 3'd1, 32'hF000_000F, 32'd5,  1, 1, 0);
    run_op("rol32",     3'd3, 32'hA5A5_0001, 32'd32, 1, 1, 0);
    run_op("ror31",     3'd4, 32'h0000_0003, 32'd31, 1, 1, 0);
    run_op("shra17",    3'd2, 32'h9000_0000, 32'd17, 1, 1, 0);

    // start while SHIFT and while DONE must be ignored.
    run_op("repulse_shift", 3'd0, 32'h0000_00FF, 32'd20, 1, 0, 3);
    run_op("repulse_done",  3'd0, 32'hFFFF_FFF0, 32'd2,  1, 0, 3);

    // Randomized operations.
    for (int i = 0; i < 30; i++) begin
      o = 3'($urandom_range(0, 7));
      d = $urandom;
      if ($urandom_range(0, 3) == 0) n = $urandom;
      else n = $urandom_range(0, 40);
      run_op("rand", o, d, n, 1, 1, 0);
    end

    // Asynchronous reset in the middle of a SHIFT sequence.
    @(negedge clock);
    op = 3'd0; data_in = 32'h0000_0F0F; num_shifts = 32'd20; start1 = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start1 = 1'b0;
    repeat (4) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst busy1", 32'(busy1), 32'd0);
    check("async_rst done1", 32'(done1), 32'd0);
    check("async_rst out1",  out1, 32'd0);
    check("async_rst ill1",  32'(ill1), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    late_done = 0;
    for (int e = 0; e < 40; e++) begin
      @(negedge clock);
      if (done1 || busy1) late_done++;
    end
    check("async_rst no_done", 32'(late_done), 32'd0);

`ifdef SHIFT_SEQ_ABORT_EN
    // Abort during the second SHIFT cycle of SHL by 8.
    @(negedge clock);
    op = 3'd0; data_in = 32'h0000_0101; num_shifts = 32'd8; start1 = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start1 = 1'b0;
    @(negedge clock);
    abort1 = 1'b1;
    @(negedge clock);
    abort1 = 1'b0;
    check("abort state", 32'(st1), 32'd0);
    check("abort out",   out1, 32'h0000_0404);
    late_done = 0;
    for (int e = 0; e < 20; e++) begin
      @(negedge clock);
      if (done1) late_done++;
    end
    check("abort no_done", 32'(late_done), 32'd0);
    // abort in IDLE together with start: start wins.
    @(negedge clock);
    op = 3'd3; data_in = 32'h8000_0000; num_shifts = 32'd1; start1 = 1'b1; abort1 = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start1 = 1'b0; abort1 = 1'b0;
    check("abort_idle busy", 32'(busy1), 32'd1);
    @(negedge clock);
    check("abort_idle done", 32'(done1), 32'd1);
    check("abort_idle out",  out1, 32'h0000_0001);
`endif

    repeat (3) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
